// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : vga_fb_arbiter
// Brief   : Single-port VGA framebuffer arbiter: scanout reads, buffered CPU
//           pixel stores and a screen-clear sweep engine. reset_i is active-low.
//           Optional macro FB_ARB_STATS_EN adds a stalled-store cycle counter.
// Revision: 1.0 - initial release
// ============================================================================
module vga_fb_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 8,
    parameter int PIXELS     = 307200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    output logic              cpu_stall_o,
    input  logic              clr_start_i,
    input  logic [DATA_W-1:0] clr_color_i,
    output logic              clr_busy_o,
    output logic              clr_done_o,
`ifdef FB_ARB_STATS_EN
    output logic [15:0]       stall_cycles_o,
`endif
    output logic [ADDR_W-1:0] fb_addr_o,
    output logic              fb_we_o,
    output logic [DATA_W-1:0] fb_wdata_o,
    input  logic [DATA_W-1:0] fb_rdata_i
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    localparam int                  c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int                  c_CNT_W = c_PTR_W + 1;
    localparam int                  c_ENT_W = ADDR_W + DATA_W;
    localparam logic [c_CNT_W-1:0]  c_FULL  = c_CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0]   c_LAST  = ADDR_W'(PIXELS - 1);

    logic [0:0]         state_q, state_d;
    logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]  clr_color_q, clr_color_d;
    logic               clr_done_q, clr_done_d;
    logic               rd_valid_q;

    logic [c_ENT_W-1:0] fifo_q [FIFO_DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] count_q, count_d;

    logic               w_push;
    logic               w_pop;
    logic               w_clr_wr;
    logic [c_ENT_W-1:0] w_head;

    assign cpu_stall_o = (count_q == c_FULL);
    assign clr_busy_o  = (state_q == S_CLEAR);
    assign clr_done_o  = clr_done_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_valid_q ? fb_rdata_i : '0;

    // Draining waits while a clear is pending or running so stores land on top of it.
    assign w_push   = cpu_we_i && !cpu_stall_o && (cpu_addr_i <= c_LAST);
    assign w_clr_wr = (state_q == S_CLEAR) && !rd_req_i;
    assign w_pop    = (state_q == S_IDLE) && !clr_start_i && !rd_req_i && (count_q != '0);
    assign w_head   = fifo_q[rd_ptr_q];

    always_comb begin
        fb_addr_o  = '0;
        fb_we_o    = 1'b0;
        fb_wdata_o = '0;
        if (rd_req_i) begin
            fb_addr_o = rd_addr_i;
        end else if (w_clr_wr) begin
            fb_addr_o  = clr_cnt_q;
            fb_we_o    = 1'b1;
            fb_wdata_o = clr_color_q;
        end else if (w_pop) begin
            fb_addr_o  = w_head[c_ENT_W-1:DATA_W];
            fb_we_o    = 1'b1;
            fb_wdata_o = w_head[DATA_W-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        clr_color_d = clr_color_q;
        clr_done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clr_start_i) begin
                    state_d     = S_CLEAR;
                    clr_color_d = clr_color_i;
                    clr_cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                if (!rd_req_i) begin
                    if (clr_cnt_q == c_LAST) begin
                        state_d    = S_IDLE;
                        clr_cnt_d  = '0;
                        clr_done_d = 1'b1;
                    end else begin
                        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = w_push ? wr_ptr_q + c_PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + c_PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_W'(1);
            2'b01:   count_d = count_q - c_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q     <= S_IDLE;
            clr_cnt_q   <= '0;
            clr_color_q <= '0;
            clr_done_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            clr_color_q <= clr_color_d;
            clr_done_q  <= clr_done_d;
            rd_valid_q  <= rd_req_i;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Entry storage needs no reset; the pointers and count define validity.
    always_ff @(posedge clock_i) begin
        if (w_push) begin
            fifo_q[wr_ptr_q] <= {cpu_addr_i, cpu_data_i};
        end
    end

`ifdef FB_ARB_STATS_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            stall_cnt_q <= '0;
        end else if (cpu_stall_o && cpu_we_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cycles_o = stall_cnt_q;
`endif

endmodule
`default_nettype wire
